// File: rtl/serial_paralelo_if.sv
// Link-side signal bundle of the serial receiver: serial bit in, recovered word,
// word strobe and lock indication out.
interface serial_paralelo_if;
    logic       serial;
    logic [8:0] paralelo_out;
    logic       word_strobe;
    logic       active;

    // master drives the wire and observes the recovered words; slave is the receiver
    modport master (
        output serial,
        input  paralelo_out,
        input  word_strobe,
        input  active
    );

    modport slave (
        input  serial,
        output paralelo_out,
        output word_strobe,
        output active
    );
endinterface

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: hunts for the comma symbol, locks after BC_LOCK
// consecutive aligned commas and then emits one 9-bit word every 8 bits.
module serial_paralelo #(
    parameter logic [7:0]  COMMA   = 8'hBC,
    parameter int unsigned BC_LOCK = 4
) (
    input  logic               clk8f,
    input  logic               reset,
    serial_paralelo_if.slave   link
);

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        ALIGNING = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(BC_LOCK);

    state_t     state_q;
    logic [7:0] sr_q;
    logic [2:0] bit_cnt_q;
    logic [3:0] bc_cnt_q;
    logic [8:0] paralelo_q;
    logic       strobe_q;
    logic       active_q;

    logic [7:0] nxt_d;
    logic [7:0] bit_match;
    logic       comma_hit;
    logic       word_done;
    logic [3:0] bc_cnt_d;
    logic [2:0] bit_cnt_d;

    // Byte that ends with the bit being sampled on this edge.
    assign nxt_d = {sr_q[6:0], link.serial};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_match
            assign bit_match[gi] = (nxt_d[gi] == COMMA[gi]);
        end
    endgenerate

    assign comma_hit = &bit_match;
    assign word_done = (bit_cnt_q == 3'd7);
    assign bc_cnt_d  = bc_cnt_q + 4'd1;
    assign bit_cnt_d = bit_cnt_q + 3'd1;

    always_ff @(posedge clk8f) begin
        if (reset) begin
            state_q    <= SEARCH;
            sr_q       <= 8'h00;
            bit_cnt_q  <= 3'd0;
            bc_cnt_q   <= 4'd0;
            paralelo_q <= 9'h000;
            strobe_q   <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            sr_q     <= nxt_d;
            strobe_q <= 1'b0;
            case (state_q)
                SEARCH: begin
                    // Bit-sliding hunt: any position may start the byte framing.
                    bit_cnt_q <= 3'd0;
                    if (comma_hit) begin
                        bc_cnt_q <= 4'd1;
                        if (LOCK_CNT == 4'd1) begin
                            state_q  <= ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= ALIGNING;
                        end
                    end
                end
                ALIGNING: begin
                    bit_cnt_q <= bit_cnt_d;
                    if (word_done) begin
                        if (comma_hit) begin
                            bc_cnt_q <= bc_cnt_d;
                            if (bc_cnt_d == LOCK_CNT) begin
                                state_q  <= ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            state_q   <= SEARCH;
                            bc_cnt_q  <= 4'd0;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt_q <= bit_cnt_d;
                    if (word_done) begin
                        strobe_q <= 1'b1;
                        // A payload byte equal to the comma cannot be told apart from idle.
                        if (comma_hit) begin
                            paralelo_q <= {1'b0, COMMA};
                        end else begin
                            paralelo_q <= {1'b1, nxt_d};
                        end
                    end
                end
                default: begin
                    state_q <= SEARCH;
                end
            endcase
        end
    end

    assign link.paralelo_out = paralelo_q;
    assign link.word_strobe  = strobe_q;
    assign link.active       = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Bench for serial_paralelo: directed lock/data sequences, a table of payload
// bytes, and random traffic checked every cycle against a bit-history model.
module tb_serial_paralelo;

    localparam logic [7:0] COMMA   = 8'hBC;
    localparam int         BC_LOCK = 4;

    logic clk8f = 1'b0;
    logic reset = 1'b1;

    serial_paralelo_if link ();

    serial_paralelo #(
        .COMMA   (COMMA),
        .BC_LOCK (BC_LOCK)
    ) dut (
        .clk8f (clk8f),
        .reset (reset),
        .link  (link)
    );

    always #5 clk8f = ~clk8f;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: remembers the last eight wire bits and the edge index at
    // which byte alignment was found; word boundaries are every 8th edge after it.
    logic       hist[$];
    int         m_t;
    int         m_anchor;
    int         m_cnt;
    bit         m_synced;
    bit         m_locked;
    logic [8:0] exp_out;
    logic       exp_strobe;
    logic       exp_active;

    int         strobe_cnt;
    logic [8:0] last_word;

    typedef struct {
        logic [7:0] in_byte;
        logic [8:0] exp_word;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (check %0d)", name, act, exp, n_checks);
    endtask

    task automatic model_update(input logic b, input logic r);
        logic [7:0] win;
        if (r) begin
            hist.delete();
            m_t = 0; m_anchor = 0; m_cnt = 0;
            m_synced = 0; m_locked = 0;
            exp_out = 9'h000; exp_strobe = 1'b0; exp_active = 1'b0;
        end else begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
            m_t++;
            win = 8'h00;
            foreach (hist[i]) win = {win[6:0], hist[i]};
            exp_strobe = 1'b0;
            if (!m_synced) begin
                if (win == COMMA) begin
                    m_synced = 1; m_anchor = m_t; m_cnt = 1;
                    if (m_cnt >= BC_LOCK) m_locked = 1;
                end
            end else if (((m_t - m_anchor) % 8) == 0) begin
                if (m_locked) begin
                    exp_strobe = 1'b1;
                    exp_out = (win == COMMA) ? {1'b0, COMMA} : {1'b1, win};
                end else if (win == COMMA) begin
                    m_cnt++;
                    if (m_cnt == BC_LOCK) m_locked = 1;
                end else begin
                    m_synced = 0;
                end
            end
            exp_active = m_locked;
        end
    endtask

    // One clk8f cycle: drive, clock, then compare all outputs against the model.
    task automatic step(input logic b, input logic r);
        link.serial = b;
        reset = r;
        @(posedge clk8f);
        #1;
        model_update(b, r);
        check("paralelo_out", link.paralelo_out, exp_out);
        check("word_strobe", {8'h00, link.word_strobe}, {8'h00, exp_strobe});
        check("active", {8'h00, link.active}, {8'h00, exp_active});
        if (link.word_strobe) begin
            strobe_cnt++;
            last_word = link.paralelo_out;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i], 1'b0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_out"}, link.paralelo_out, 9'h000);
        check({name, "_strobe"}, {8'h00, link.word_strobe}, 9'h000);
        check({name, "_active"}, {8'h00, link.active}, 9'h000);
    endtask

    initial begin
        logic [7:0] d;
        int act_sel;
        vecs[0] = '{8'hA5, 9'h1A5};
        vecs[1] = '{8'h3C, 9'h13C};
        vecs[2] = '{8'hBC, 9'h0BC};
        vecs[3] = '{8'h00, 9'h100};
        vecs[4] = '{8'hFF, 9'h1FF};
        vecs[5] = '{8'h7E, 9'h17E};
        link.serial = 1'b0;
        strobe_cnt = 0;
        last_word = 9'h000;

        // Reset with random wire activity.
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1);
            check_idle_outputs("reset");
        end
        step(1'b0, 1'b0);
        check_idle_outputs("release");
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Lock on four aligned commas.
        strobe_cnt = 0;
        for (int k = 0; k < 3; k++) send_byte(COMMA);
        check("lock_3rd_comma_active", {8'h00, link.active}, 9'h000);
        send_byte(COMMA);
        check("lock_4th_comma_active", {8'h00, link.active}, 9'h001);
        check("lock_no_strobe", 9'(strobe_cnt), 9'd0);

        // Payload table while locked.
        for (int v = 0; v < 6; v++) begin
            strobe_cnt = 0;
            send_byte(vecs[v].in_byte);
            check($sformatf("vec%0d_strobes", v), 9'(strobe_cnt), 9'd1);
            check($sformatf("vec%0d_word", v), last_word, vecs[v].exp_word);
            check($sformatf("vec%0d_active", v), {8'h00, link.active}, 9'h001);
        end

        // Broken alignment run, then relock.
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        strobe_cnt = 0;
        send_byte(COMMA);
        send_byte(COMMA);
        send_byte(8'h55);
        check("abort_active", {8'h00, link.active}, 9'h000);
        for (int k = 0; k < 3; k++) send_byte(COMMA);
        check("relock_3_active", {8'h00, link.active}, 9'h000);
        send_byte(COMMA);
        check("relock_4_active", {8'h00, link.active}, 9'h001);
        check("relock_no_strobe", 9'(strobe_cnt), 9'd0);

        // Reset in the middle of a data byte.
        d = 8'hC3;
        for (int i = 7; i >= 5; i--) step(d[i], 1'b0);
        step(d[4], 1'b1);
        check_idle_outputs("midword_reset");
        strobe_cnt = 0;
        send_byte(8'hA5);
        for (int k = 0; k < 4; k++) send_byte(COMMA);
        check("post_reset_no_strobe", 9'(strobe_cnt), 9'd0);
        check("post_reset_active", {8'h00, link.active}, 9'h001);
        send_byte(8'h5A);
        check("post_reset_strobes", 9'(strobe_cnt), 9'd1);
        check("post_reset_word", last_word, 9'h15A);

        // Random traffic: commas, data, bit slips and occasional resets.
        for (int n = 0; n < 400; n++) begin
            act_sel = int'($urandom_range(0, 99));
            if (act_sel < 55) send_byte(COMMA);
            else if (act_sel < 88) send_byte(8'($urandom));
            else if (act_sel < 96) step(1'($urandom_range(0, 1)), 1'b0);
            else step(1'($urandom_range(0, 1)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
